// File: rtl/dcache_wb.sv
// Write-back, write-allocate, set-associative data cache with a word-serial refill/eviction port.
// Define DCACHE_PERF_EN to build the hit/miss performance counters; otherwise perf_* read 0.
//
// state  | meaning
// S_IDLE | serving hits; a missing request starts a line transfer
// S_WB   | writing the dirty victim line back, one beat per ack
// S_FILL | reading the requested line into the victim way
// S_DONE | one settle cycle before the retried request hits
module dcache_wb #(
  parameter int SET_CNT    = 16,
  parameter int WAY_CNT    = 2,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] cpu_addr,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [3:0]  cpu_be,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        dcache_miss,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [31:0] perf_hit,
  output logic [31:0] perf_miss
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(SET_CNT);
  localparam int TAG_W = 30 - OFF_W - IDX_W;
  localparam int WAY_W = (WAY_CNT > 1) ? $clog2(WAY_CNT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WB, S_FILL, S_DONE} state_t;

  logic [31:0]      r_data  [WAY_CNT][SET_CNT][LINE_WORDS];
  logic [TAG_W-1:0] r_tag   [WAY_CNT][SET_CNT];
  logic             r_valid [WAY_CNT][SET_CNT];
  logic             r_dirty [WAY_CNT][SET_CNT];
  logic [WAY_W-1:0] r_rr    [SET_CNT];

  state_t           r_state, w_state_nxt;
  logic [OFF_W-1:0] r_beat, w_beat_nxt;
  logic [WAY_W-1:0] r_vway, w_vway_nxt;
  logic [IDX_W-1:0] r_idx, w_idx_nxt;
  logic [TAG_W-1:0] r_rtag, w_rtag_nxt;
  logic             r_mem_req, w_mem_req_nxt;
  logic             r_mem_we, w_mem_we_nxt;
  logic [31:0]      r_mem_addr, w_mem_addr_nxt;
  logic [31:0]      r_mem_wdata, w_mem_wdata_nxt;

  logic [OFF_W-1:0] w_off;
  logic [IDX_W-1:0] w_idx;
  logic [TAG_W-1:0] w_tag;
  logic             w_req, w_hit, w_ack, w_last, w_store, w_fill_ack, w_start;
  logic [WAY_W-1:0] w_hit_way, w_victim;
  logic [OFF_W-1:0] w_beat_inc;

  assign w_off      = cpu_addr[OFF_W+1:2];
  assign w_idx      = cpu_addr[OFF_W+2 +: IDX_W];
  assign w_tag      = cpu_addr[31 -: TAG_W];
  assign w_req      = cpu_rd | cpu_wr;
  assign w_ack      = mem_ack & r_mem_req;
  assign w_last     = (r_beat == {OFF_W{1'b1}});
  assign w_beat_inc = r_beat + OFF_W'(1);
  assign w_store    = (r_state == S_IDLE) & cpu_wr & w_hit;
  assign w_fill_ack = (r_state == S_FILL) & w_ack;

  // Lowest invalid way wins as victim; the loop runs downward so it overrides higher ways.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    w_victim  = r_rr[w_idx];
    for (int w = WAY_CNT - 1; w >= 0; w--) begin
      if (!r_valid[w][w_idx]) w_victim = WAY_W'(w);
      if (r_valid[w][w_idx] && (r_tag[w][w_idx] == w_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = WAY_W'(w);
      end
    end
  end

  assign cpu_rdata   = (cpu_rd && w_hit) ? r_data[w_hit_way][w_idx][w_off] : '0;
  assign dcache_miss = (r_state != S_IDLE) | (w_req & ~w_hit);

  always_comb begin
    w_state_nxt     = r_state;
    w_beat_nxt      = r_beat;
    w_vway_nxt      = r_vway;
    w_idx_nxt       = r_idx;
    w_rtag_nxt      = r_rtag;
    w_mem_req_nxt   = r_mem_req;
    w_mem_we_nxt    = r_mem_we;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_start         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req && !w_hit) begin
          w_start       = 1'b1;
          w_vway_nxt    = w_victim;
          w_idx_nxt     = w_idx;
          w_rtag_nxt    = w_tag;
          w_beat_nxt    = '0;
          w_mem_req_nxt = 1'b1;
          if (r_valid[w_victim][w_idx] && r_dirty[w_victim][w_idx]) begin
            w_state_nxt     = S_WB;
            w_mem_we_nxt    = 1'b1;
            w_mem_addr_nxt  = {r_tag[w_victim][w_idx], w_idx, {OFF_W{1'b0}}, 2'b00};
            w_mem_wdata_nxt = r_data[w_victim][w_idx][{OFF_W{1'b0}}];
          end else begin
            w_state_nxt     = S_FILL;
            w_mem_we_nxt    = 1'b0;
            w_mem_addr_nxt  = {w_tag, w_idx, {OFF_W{1'b0}}, 2'b00};
            w_mem_wdata_nxt = '0;
          end
        end
      end
      S_WB: begin
        if (w_ack) begin
          w_beat_nxt = w_beat_inc;
          if (w_last) begin
            w_state_nxt     = S_FILL;
            w_mem_we_nxt    = 1'b0;
            w_mem_addr_nxt  = {r_rtag, r_idx, {OFF_W{1'b0}}, 2'b00};
            w_mem_wdata_nxt = '0;
          end else begin
            w_mem_addr_nxt  = {r_tag[r_vway][r_idx], r_idx, w_beat_inc, 2'b00};
            w_mem_wdata_nxt = r_data[r_vway][r_idx][w_beat_inc];
          end
        end
      end
      S_FILL: begin
        if (w_ack) begin
          w_beat_nxt = w_beat_inc;
          if (w_last) begin
            w_state_nxt    = S_DONE;
            w_mem_req_nxt  = 1'b0;
            w_mem_addr_nxt = '0;
          end else begin
            w_mem_addr_nxt = {r_rtag, r_idx, w_beat_inc, 2'b00};
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_beat      <= '0;
      r_vway      <= '0;
      r_idx       <= '0;
      r_rtag      <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_beat      <= w_beat_nxt;
      r_vway      <= w_vway_nxt;
      r_idx       <= w_idx_nxt;
      r_rtag      <= w_rtag_nxt;
      r_mem_req   <= w_mem_req_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
    end
  end

  // Line becomes valid only on the last fill beat, so an aborted burst leaves it invalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SET_CNT; s++) begin
        r_rr[s] <= '0;
        for (int w = 0; w < WAY_CNT; w++) begin
          r_valid[w][s] <= 1'b0;
          r_dirty[w][s] <= 1'b0;
        end
      end
    end else if (w_fill_ack && w_last) begin
      r_valid[r_vway][r_idx] <= 1'b1;
      r_dirty[r_vway][r_idx] <= 1'b0;
      r_rr[r_idx] <= (r_rr[r_idx] == WAY_W'(WAY_CNT - 1)) ? '0 : r_rr[r_idx] + WAY_W'(1);
    end else if (w_store) begin
      r_dirty[w_hit_way][w_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_fill_ack) begin
      r_data[r_vway][r_idx][r_beat] <= mem_rdata;
      if (w_last) r_tag[r_vway][r_idx] <= r_rtag;
    end else if (w_store) begin
      for (int b = 0; b < 4; b++)
        if (cpu_be[b]) r_data[w_hit_way][w_idx][w_off][8*b +: 8] <= cpu_wdata[8*b +: 8];
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

`ifdef DCACHE_PERF_EN
  logic        r_after_done;
  logic [31:0] r_perf_hit, r_perf_miss;

  // Retries completing a miss are excluded from the hit count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_after_done <= 1'b0;
      r_perf_hit   <= '0;
      r_perf_miss  <= '0;
    end else begin
      r_after_done <= (r_state == S_DONE);
      if ((r_state == S_IDLE) && w_req && w_hit && !r_after_done) r_perf_hit <= r_perf_hit + 32'd1;
      if (w_start) r_perf_miss <= r_perf_miss + 32'd1;
    end
  end

  assign perf_hit  = r_perf_hit;
  assign perf_miss = r_perf_miss;
`else
  assign perf_hit  = '0;
  assign perf_miss = '0;
`endif

endmodule

// File: tb/tb_dcache_wb.sv
// Scoreboard bench for dcache_wb: a negedge monitor/memory model checks beats and load data
// against queues filled by the directed stimulus.
module tb_dcache_wb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic        cpu_rd = 1'b0;
  logic        cpu_wr = 1'b0;
  logic [3:0]  cpu_be = '0;
  logic [31:0] cpu_wdata = '0;
  logic [31:0] cpu_rdata;
  logic        dcache_miss;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic [31:0] perf_hit, perf_miss;

  dcache_wb dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_addr(cpu_addr), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_be(cpu_be), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .dcache_miss(dcache_miss),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .perf_hit(perf_hit), .perf_miss(perf_miss)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } beat_t;

  beat_t       sb_beat[$];
  logic [31:0] sb_rd[$];
  logic [31:0] mem [int unsigned];
  int          total = 0;
  int          bad = 0;
  int          lat = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pattern(input logic [31:0] a);
    return 32'hC0DE_0000 | {16'h0, a[15:0]};
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return pattern(a);
  endfunction

  task automatic exp_fill(input logic [31:0] base);
    for (int i = 0; i < 4; i++) sb_beat.push_back('{1'b0, base + 32'(4*i), 32'h0});
  endtask

  // Memory model plus monitor: acks after lat wait cycles, scores every accepted beat and load.
  int          wait_cnt = 0;
  logic        prev_pend = 1'b0;
  logic [31:0] prev_addr = '0;
  logic        prev_we = 1'b0;
  always @(negedge clk) begin
    logic  ackn;
    beat_t e;
    ackn = 1'b0;
    if (!rst_n) begin
      mem_ack   = 1'b0;
      wait_cnt  = 0;
      prev_pend = 1'b0;
    end else begin
      if (prev_pend) begin
        chk("hold_req", {31'b0, mem_req}, 32'd1);
        chk("hold_addr", mem_addr, prev_addr);
        chk("hold_we", {31'b0, mem_we}, {31'b0, prev_we});
      end
      if (mem_req) begin
        if (wait_cnt == lat) begin
          ackn = 1'b1;
          wait_cnt = 0;
          if (mem_we) mem[mem_addr] = mem_wdata;
          else mem_rdata = mem_rd(mem_addr);
          if (sb_beat.size() == 0) begin
            total++;
            bad++;
            $display("FAIL beat_unexpected: got addr %h we %0d want none", mem_addr, mem_we);
          end else begin
            e = sb_beat.pop_front();
            chk("beat_we", {31'b0, mem_we}, {31'b0, e.we});
            chk("beat_addr", mem_addr, e.addr);
            if (e.we) chk("beat_wdata", mem_wdata, e.data);
          end
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
      mem_ack   = ackn;
      prev_pend = mem_req && !ackn;
      prev_addr = mem_addr;
      prev_we   = mem_we;
      if (cpu_rd && !dcache_miss) begin
        if (sb_rd.size() == 0) begin
          total++;
          bad++;
          $display("FAIL load_unexpected: got %h want none", cpu_rdata);
        end else begin
          chk("load_data", cpu_rdata, sb_rd.pop_front());
        end
      end
    end
  end

  // Issues one request, holds it while dcache_miss is high and checks the stall length.
  task automatic do_req(input logic wr, input logic [31:0] addr, input logic [3:0] be,
                        input logic [31:0] wdata, input int exp_cnt);
    int cnt;
    @(posedge clk);
    #1;
    cpu_addr  = addr;
    cpu_be    = be;
    cpu_wdata = wdata;
    cpu_wr    = wr;
    cpu_rd    = !wr;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (!dcache_miss) break;
      cnt++;
      if (cnt > 200) begin
        total++;
        bad++;
        $display("FAIL req_timeout: addr %h still stalled after %0d cycles", addr, cnt);
        break;
      end
    end
    chk("miss_cycles", 32'(cnt), 32'(exp_cnt));
    @(posedge clk);
    #1;
    cpu_rd = 1'b0;
    cpu_wr = 1'b0;
  endtask

  task automatic load(input logic [31:0] addr, input logic [31:0] exp_data, input int exp_cnt);
    sb_rd.push_back(exp_data);
    do_req(1'b0, addr, 4'h0, 32'h0, exp_cnt);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_miss", {31'b0, dcache_miss}, 32'd0);
    chk("rst_rdata", cpu_rdata, 32'h0);
    chk("rst_req", {31'b0, mem_req}, 32'd0);
    chk("rst_we", {31'b0, mem_we}, 32'd0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_perf_hit", perf_hit, 32'd0);
    chk("rst_perf_miss", perf_miss, 32'd0);

    // cold load: 4 beats + DONE after the request cycle
    exp_fill(32'h40);
    load(32'h40, 32'hC0DE_0040, 6);
`ifdef DCACHE_PERF_EN
    chk("cold_perf_miss", perf_miss, 32'd1);
`else
    chk("cold_perf_miss", perf_miss, 32'd0);
`endif

    // byte-enable merge into a line holding 0x11223344
    mem[32'h80] = 32'h1122_3344;
    exp_fill(32'h80);
    do_req(1'b1, 32'h80, 4'b0101, 32'hAABB_CCDD, 6);
    load(32'h80, 32'h11BB_33DD, 0);
    load(32'h84, 32'hC0DE_0084, 0);

    // dirty eviction in set 0
    exp_fill(32'h000);
    load(32'h000, 32'hC0DE_0000, 6);
    exp_fill(32'h100);
    load(32'h100, 32'hC0DE_0100, 6);
    do_req(1'b1, 32'h000, 4'b1111, 32'hDEAD_BEEF, 0);
    sb_beat.push_back('{1'b1, 32'h000, 32'hDEAD_BEEF});
    sb_beat.push_back('{1'b1, 32'h004, 32'hC0DE_0004});
    sb_beat.push_back('{1'b1, 32'h008, 32'hC0DE_0008});
    sb_beat.push_back('{1'b1, 32'h00C, 32'hC0DE_000C});
    exp_fill(32'h200);
    load(32'h200, 32'hC0DE_0200, 10);
    exp_fill(32'h000);
    load(32'h000, 32'hDEAD_BEEF, 6);

    // round-robin in set 3: ways 0, 1, 0
    exp_fill(32'h030);
    load(32'h030, 32'hC0DE_0030, 6);
    exp_fill(32'h130);
    load(32'h130, 32'hC0DE_0130, 6);
    exp_fill(32'h230);
    load(32'h230, 32'hC0DE_0230, 6);
    load(32'h130, 32'hC0DE_0130, 0);
    exp_fill(32'h030);
    load(32'h030, 32'hC0DE_0030, 6);
    load(32'h230, 32'hC0DE_0230, 0);
`ifdef DCACHE_PERF_EN
    chk("perf_hit", perf_hit, 32'd5);
    chk("perf_miss", perf_miss, 32'd10);
`else
    chk("perf_hit", perf_hit, 32'd0);
    chk("perf_miss", perf_miss, 32'd0);
`endif

    // reset during FILL beat 2
    exp_fill(32'h050);
    @(posedge clk);
    #1;
    cpu_addr = 32'h050;
    cpu_rd   = 1'b1;
    n = 0;
    while (!(mem_req && mem_addr == 32'h058) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("rst_beat2_reached", mem_addr, 32'h058);
    #1;
    rst_n  = 1'b0;
    cpu_rd = 1'b0;
    #1;
    chk("rst_async_req", {31'b0, mem_req}, 32'd0);
    repeat (2) begin
      @(negedge clk);
      chk("rst_low_req", {31'b0, mem_req}, 32'd0);
    end
    sb_beat.delete();
    sb_rd.delete();
    rst_n = 1'b1;
    exp_fill(32'h050);
    load(32'h050, 32'hC0DE_0050, 6);
    exp_fill(32'h040);
    load(32'h040, 32'hC0DE_0040, 6);

    // back-pressure: ack after 3 wait cycles per beat
    lat = 3;
    exp_fill(32'h060);
    load(32'h060, 32'hC0DE_0060, 18);
    load(32'h06C, 32'hC0DE_006C, 0);

    repeat (5) @(negedge clk);
    chk("beat_queue_empty", 32'(sb_beat.size()), 32'd0);
    chk("load_queue_empty", 32'(sb_rd.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
